uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
// - Parametrised UART receiver, successor to the fixed 8N1 receiver: configurable data width, run-time parity and stop-bit mode.
// - Detects false starts, parity and framing errors; optional break detection.
// - Sits between the asynchronous RX pin and the host/FIFO logic; one-cycle valid pulse per received frame, no backpressure.
// PARAMETERS
// - CLK_FREQ      100000000  system clock, Hz
// - BAUD_RATE     115200     line rate, baud
// - OVERSAMPLING  16         ticks per bit; even, >=8
// - DATA_BITS     8          data bits per frame, 5..9
// PORTS
// - i_clk         in   1          system clock
// - i_aresetn     in   1          reset, asynchronous, active-low
// - i_rx_data     in   1          serial line, asynchronous, idle high
// - i_parity_en   in   1          1 = parity bit present after data
// - i_parity_odd  in   1          1 = odd parity, 0 = even
// - i_two_stop    in   1          1 = two stop bits checked
// - o_rx_data     out  DATA_BITS  received word, LSB first on line; valid with o_rx_valid
// - o_rx_valid    out  1          1-cycle pulse, frame complete (also on error)
// - o_parity_err  out  1          parity mismatch, qualified by o_rx_valid
// - o_frame_err   out  1          stop bit sampled low, qualified by o_rx_valid
// - o_rx_busy     out  1          high from accepted start edge to end of frame
// - o_break       out  1          1-cycle pulse, break detected (UART_RX_BREAK_DET_EN only)
// BEHAVIOUR
// - Reset: all outputs 0; o_rx_data 0; state IDLE; filter window all-ones.
// - Tick: internal divider, period CLK_FREQ/(BAUD_RATE*OVERSAMPLING) clocks (integer, truncated), free-running, cleared by reset.
// - Input: 2-flop synchroniser every clock; 3-sample majority filter shifted on tick; filtered bit registered.
// - Config inputs latched on IDLE->START; changes mid-frame have no effect on the current frame.
// - FSM (advances only on tick):
//   IDLE   : filtered=0 -> START, sample cnt=1, busy=1.
//   START  : at cnt==OVERSAMPLING/2-1 re-sample; 0 -> DATA (cnt=0, bit=0); 1 -> false start, IDLE, busy=0, no valid.
//   DATA   : sample every OVERSAMPLING ticks (mid-bit); shift in LSB-first; after bit DATA_BITS-1 -> PARITY if enabled else STOP.
//   PARITY : sample; err = (XOR(data)^bit) != i_parity_odd latched value.
//   STOP   : sample stop1 (and stop2 if two-stop, OVERSAMPLING ticks later); any 0 -> frame_err.
//            After last stop sample (mid-bit) -> IDLE; valid pulses next clock; busy falls same clock as valid.
//   BRKWAIT: (macro only) wait filtered==1 for one tick, then IDLE; busy stays 1 here.
// - Outputs registered; o_rx_data/o_parity_err/o_frame_err hold until next valid.
// - Latency: valid 1 clock after mid-sample of final stop bit.
// - Frame error without macro: return to IDLE; a still-low line is treated as a new start edge.
// - Reset asserted mid-frame: immediate abort, no valid, outputs to reset values.
// - Counters: sample cnt width clog2(OVERSAMPLING), bit cnt width clog2(DATA_BITS); wrap to 0 on each bit.
// CONFIGURATION
// - UART_RX_BREAK_DET_EN defined: frame with all data=0, parity bit=0 (if enabled), stop=0 -> o_break pulse with o_rx_valid, o_frame_err=1;
//   FSM enters BRKWAIT, no new start accepted until line returns high.
// - Not defined: o_break tied 0, no BRKWAIT state; break reported as frame error with data 0.
// TESTING
// - 8N1, 115200, byte 0xA5 -> one o_rx_valid, o_rx_data=0xA5, errs 0, busy low after valid.
// - DATA_BITS=7, even parity, 2 stop, 0x41 with parity bit 0 -> data 0x41, parity_err 0; flip parity bit -> parity_err 1.
// - Low glitch 3 ticks (< OVERSAMPLING/2) on idle line -> no valid, busy returns 0, FSM IDLE.
// - 8N1, 0x3C, stop bit driven low -> valid, data 0x3C, frame_err 1.
// - Macro on: line low 20 bit times -> one o_break pulse, frame_err 1, next frame 0x55 after line high received correctly.
// - Reset pulse mid-DATA of 0xFF -> no valid; following 0x12 received correctly; baud mismatch +2% on 0x5A -> data 0x5A.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with configurable data width, run-time parity and stop bits.
// Define UART_RX_BREAK_DET_EN to enable break detection (o_break and the BRKWAIT state).
module uart_rx_frame #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_aresetn,
    input  logic                 i_rx_data,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_two_stop,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_rx_busy,
    output logic                 o_break
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLING);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [SW-1:0] HALF  = SW'(OVERSAMPLING / 2 - 1);
    localparam logic [SW-1:0] LAST  = SW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_BREAK_DET_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    sync;
    logic [2:0]    win;
    logic          filt;
    assign tick = div_cnt == DW'(DIV - 1);
    // synchroniser and filter idle high so reset never looks like a start edge
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            div_cnt <= '0;
            sync    <= 2'b11;
            win     <= 3'b111;
            filt    <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            sync    <= {sync[0], i_rx_data};
            if (tick) begin
                win  <= {win[1:0], sync[1]};
                filt <= (win[1] & win[0]) | (win[1] & sync[1]) | (win[0] & sync[1]);
            end
        end
    end
    state_t               state, state_n;
    logic [SW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [2:0]           cfg, cfg_n;
    logic                 perr, perr_n, ferr, ferr_n, pzero, pzero_n, fin, brk, mid;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bcnt_n  = bcnt;
        sh_n    = sh;
        cfg_n   = cfg;
        perr_n  = perr;
        ferr_n  = ferr;
        pzero_n = pzero;
        fin     = 1'b0;
        brk     = 1'b0;
        mid     = cnt == LAST;
        if (tick) begin
            cnt_n = mid ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (!filt) begin
                    state_n = START;
                    cnt_n   = SW'(1);
                    cfg_n   = {i_parity_en, i_parity_odd, i_two_stop};
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    pzero_n = 1'b1;
                end
                START: if (cnt == HALF) begin
                    state_n = filt ? IDLE : DATA;
                    cnt_n   = '0;
                    bcnt_n  = '0;
                end
                DATA: if (mid) begin
                    sh_n    = {filt, sh[DATA_BITS-1:1]};
                    bcnt_n  = (bcnt == BLAST) ? '0 : bcnt + 1'b1;
                    state_n = (bcnt != BLAST) ? DATA : cfg[2] ? PARITY : STOP;
                end
                PARITY: if (mid) begin
                    perr_n  = ((^sh) ^ filt) != cfg[1];
                    pzero_n = !filt;
                    state_n = STOP;
                end
                STOP: if (mid) begin
                    ferr_n = ferr | !filt;
                    bcnt_n = bcnt + 1'b1;
                    if (!cfg[0] || bcnt != '0) begin
                        fin     = 1'b1;
                        bcnt_n  = '0;
                        state_n = IDLE;
`ifdef UART_RX_BREAK_DET_EN
                        brk     = ferr_n && pzero && sh == '0;
                        state_n = brk ? BRKWAIT : IDLE;
`endif
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                BRKWAIT: if (filt) state_n = IDLE;
`endif
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state        <= IDLE;
            cnt          <= '0;
            bcnt         <= '0;
            sh           <= '0;
            cfg          <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            pzero        <= 1'b1;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_rx_busy    <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bcnt       <= bcnt_n;
            sh         <= sh_n;
            cfg        <= cfg_n;
            perr       <= perr_n;
            ferr       <= ferr_n;
            pzero      <= pzero_n;
            o_rx_valid <= fin;
            o_rx_busy  <= state_n != IDLE;
            o_break    <= brk;
            if (fin) begin
                o_rx_data    <= sh_n;
                o_parity_err <= perr_n;
                o_frame_err  <= ferr_n;
            end
        end
    end
endmodule
